conn_state_ctrl: RTL

CONN_STATE_CTRL -- requirements
Module: conn_state_ctrl

---
 rtl/conn_state_ctrl_if.sv | 25 ++
 rtl/conn_state_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/conn_state_ctrl_if.sv
// Bundle of the user command, network handshake and status report streams of conn_state_ctrl.
// Every stream is valid/ready: a transfer happens on a rising edge where both are high (hs_resp is a bare pulse).
interface conn_state_ctrl_if;
   logic [1:0]  cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  hs_req_type;
   logic        hs_req_valid;
   logic        hs_req_ready;
   logic        hs_resp_valid;
   logic [1:0]  hs_resp_type;
   logic [31:0] udt_state;
   logic        state_valid;
   logic        state_ready;

   modport slave (
      input  cmd_data, cmd_valid, hs_req_ready, hs_resp_valid, hs_resp_type, state_ready,
      output cmd_ready, hs_req_type, hs_req_valid, udt_state, state_valid
   );

   modport master (
      output cmd_data, cmd_valid, hs_req_ready, hs_resp_valid, hs_resp_type, state_ready,
      input  cmd_ready, hs_req_type, hs_req_valid, udt_state, state_valid
   );
endinterface

// File: rtl/conn_state_ctrl.sv
// Connection open/close controller: drives connect/shutdown handshakes with timeout and retry,
// and publishes status reports through a one-entry latest-wins register.
module conn_state_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                   ctrl_s_axi_aclk,
   input  logic                   ctrl_s_axi_aresetn,
   conn_state_ctrl_if.slave       bus,
   output logic [2:0]             fsm_state_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND_CONN = 3'd1,
      WAIT_CONN = 3'd2,
      CONNECTED = 3'd3,
      SEND_SHUT = 3'd4,
      WAIT_SHUT = 3'd5,
      CLOSED    = 3'd6
   } state_e;

   localparam logic [1:0]  CMD_OPEN       = 2'b01;
   localparam logic [1:0]  CMD_CLOSE      = 2'b10;
   localparam logic [1:0]  RESP_ACCEPT    = 2'b00;
   localparam logic [1:0]  RESP_REJECT    = 2'b01;
   localparam logic [1:0]  RESP_SHUT_ACK  = 2'b10;
   localparam logic [3:0]  RPT_CONNECTING = 4'd1;
   localparam logic [3:0]  RPT_CONNECTED  = 4'd2;
   localparam logic [3:0]  RPT_CLOSING    = 4'd3;
   localparam logic [3:0]  RPT_CLOSED     = 4'd4;
   localparam logic [3:0]  RPT_CONN_FAIL  = 4'd5;
   localparam logic [3:0]  RPT_CLOSE_FAIL = 4'd6;
   localparam logic [31:0] TIMER_LAST     = 32'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  retry_q, retry_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] udt_q;
   logic        svalid_q;
   logic        live_q;
   logic        cmd_fire;
   logic        timeout;
   logic        rpt_fire;
   logic [3:0]  rpt_code;
   logic [31:0] rpt_word;

   // live_q keeps cmd_ready low on the reset edge itself; it rises one cycle after release.
   assign bus.cmd_ready    = live_q && (state_q == IDLE || state_q == CONNECTED || state_q == CLOSED);
   assign bus.hs_req_valid = (state_q == SEND_CONN) || (state_q == SEND_SHUT);
   assign bus.hs_req_type  = (state_q == SEND_SHUT) ? 2'b01 : 2'b00;
   assign bus.udt_state    = udt_q;
   assign bus.state_valid  = svalid_q;
   assign fsm_state_o      = state_q;

   assign cmd_fire = bus.cmd_ready && bus.cmd_valid;
   assign timeout  = (timer_q == TIMER_LAST);
   assign rpt_word = {16'h0000, retry_d, 4'h0, rpt_code};

   always_comb begin
      state_d  = state_q;
      retry_d  = retry_q;
      timer_d  = timer_q;
      rpt_fire = 1'b0;
      rpt_code = 4'd0;
      case (state_q)
         IDLE, CLOSED: begin
            if (cmd_fire && bus.cmd_data == CMD_OPEN) begin
               retry_d  = 8'd0;
               state_d  = SEND_CONN;
               rpt_fire = 1'b1;
               rpt_code = RPT_CONNECTING;
            end else if (cmd_fire && bus.cmd_data == CMD_CLOSE) begin
               rpt_fire = 1'b1;
               rpt_code = RPT_CLOSE_FAIL;
            end
         end
         CONNECTED: begin
            if (cmd_fire && bus.cmd_data == CMD_OPEN) begin
               rpt_fire = 1'b1;
               rpt_code = RPT_CONN_FAIL;
            end else if (cmd_fire && bus.cmd_data == CMD_CLOSE) begin
               state_d  = SEND_SHUT;
               rpt_fire = 1'b1;
               rpt_code = RPT_CLOSING;
            end
         end
         SEND_CONN: begin
            if (bus.hs_req_ready) begin
               state_d = WAIT_CONN;
               timer_d = 32'd0;
            end
         end
         SEND_SHUT: begin
            if (bus.hs_req_ready) begin
               state_d = WAIT_SHUT;
               timer_d = 32'd0;
            end
         end
         WAIT_CONN: begin
            timer_d = timer_q + 32'd1;
            // A response landing on the timeout cycle takes priority over the timeout.
            if (bus.hs_resp_valid && bus.hs_resp_type == RESP_ACCEPT) begin
               state_d  = CONNECTED;
               rpt_fire = 1'b1;
               rpt_code = RPT_CONNECTED;
            end else if (bus.hs_resp_valid && bus.hs_resp_type == RESP_REJECT) begin
               state_d  = CLOSED;
               rpt_fire = 1'b1;
               rpt_code = RPT_CONN_FAIL;
            end else if (timeout) begin
               rpt_fire = 1'b1;
               if (32'(retry_q) < MAX_RETRY) begin
                  retry_d  = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
                  state_d  = SEND_CONN;
                  rpt_code = RPT_CONNECTING;
               end else begin
                  state_d  = CLOSED;
                  rpt_code = RPT_CONN_FAIL;
               end
            end
         end
         WAIT_SHUT: begin
            timer_d = timer_q + 32'd1;
            if ((bus.hs_resp_valid && bus.hs_resp_type == RESP_SHUT_ACK) || timeout) begin
               state_d  = CLOSED;
               rpt_fire = 1'b1;
               rpt_code = RPT_CLOSED;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ctrl_s_axi_aclk) begin
      if (!ctrl_s_axi_aresetn) begin
         state_q  <= IDLE;
         retry_q  <= 8'd0;
         timer_q  <= 32'd0;
         udt_q    <= 32'd0;
         svalid_q <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         live_q  <= 1'b1;
         // Latest report wins; an unread one is simply overwritten.
         if (rpt_fire) begin
            udt_q    <= rpt_word;
            svalid_q <= 1'b1;
         end else if (svalid_q && bus.state_ready) begin
            svalid_q <= 1'b0;
         end
      end
   end

endmodule
